// File: rtl/shift_reg_sequencer_pkg.sv
// shift_reg_sequencer_pkg: shared encodings for the shift register sequencer
package shift_reg_sequencer_pkg;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SHL = 2'b01, OP_SHR = 2'b10, OP_ROTL = 2'b11} op_e;
  typedef enum logic [1:0] {SEL_HOLD = 2'b00, SEL_LEFT = 2'b01, SEL_RIGHT = 2'b10, SEL_LOAD = 2'b11} sel_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_EXEC = 2'b01, ST_DONE = 2'b10} state_e;
  function automatic sel_e op_to_sel(op_e op);
    return op == OP_LOAD ? SEL_LOAD : op == OP_SHR ? SEL_RIGHT : SEL_LEFT;
  endfunction
  // Rotate feedback: the first shift wraps the current MSB; later shifts wrap the bit about to become MSB.
  function automatic logic rotl_ser(logic [7:0] q, logic first);
    return first ? q[7] : q[6];
  endfunction
endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down-counter with zero flag, falling-edge clocked
module seq_down_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(negedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: command-driven controller for an 8-bit universal shift register
module shift_reg_sequencer
  import shift_reg_sequencer_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       reg_sel,
  output logic             reg_ser,
  output logic [WIDTH-1:0] reg_par,
  output logic             busy,
  output logic             done
);
  state_e           r_state;
  op_e              r_op;
  sel_e             r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_fill, r_ser, r_busy, r_done, r_ready;
  logic             w_zero, w_accept;
  op_e              w_op;
  assign w_op     = op_e'(cmd_op);
  assign w_accept = r_state == ST_IDLE && cmd_valid;
  seq_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_dec  (r_state == ST_EXEC && !w_zero),
    .i_val  (w_op == OP_LOAD ? '0 : cmd_cnt),
    .o_zero (w_zero)
  );
  always_ff @(negedge clk or posedge reset)
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LOAD;
      r_sel   <= SEL_HOLD;
      r_data  <= '0;
      r_fill  <= 1'b0;
      r_ser   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else
      case (r_state)
        ST_IDLE:
          if (cmd_valid) begin
            r_op    <= w_op;
            r_data  <= cmd_data;
            r_fill  <= cmd_fill;
            r_sel   <= op_to_sel(w_op);
            r_ser   <= w_op == OP_ROTL ? rotl_ser(reg_q, 1'b1) : cmd_fill;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= ST_EXEC;
          end
        ST_EXEC:
          if (w_zero) begin
            r_sel   <= SEL_HOLD;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else
            r_ser <= r_op == OP_ROTL ? rotl_ser(reg_q, 1'b0) : r_fill;
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
  assign cmd_ready = r_ready;
  assign reg_sel   = r_sel;
  assign reg_ser   = r_ser;
  assign reg_par   = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule
